// File: rtl/gray_rx_checker_pkg.sv
// Shared types for the Gray receive checker: FSM state encoding and a reference decoder.
package gray_rx_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int GRAY_W = 4;

  // Reflected-Gray to binary at the counter's native width; handy for its testbench too.
  function automatic logic [GRAY_W-1:0] gray_to_bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    for (int i = 0; i < GRAY_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_rx_checker_gray2bin.sv
// Combinational W-bit reflected-Gray to binary decoder.
module gray_rx_checker_gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_rx_checker.sv
// Samples a Gray-coded bus, decodes it, and classifies each step against the previous code.
//
// state | meaning
// IDLE  | no reference code; next valid sample becomes the reference
// TRACK | classifying each sample as up, down, hold or illegal jump
// FAULT | ERR_LIMIT consecutive illegal jumps seen; decode only until resync
module gray_rx_checker
  import gray_rx_checker_pkg::*;
#(
  parameter int W         = 4,
  parameter int ERR_LIMIT = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             c,
  input  logic [W-1:0]     gray_in,
  input  logic             valid_in,
  input  logic             resync,
  output logic [W-1:0]     bin_out,
  output logic             valid_out,
  output logic             step_up,
  output logic             step_dn,
  output logic             hold,
  output logic             wrap,
  output logic             err,
  output logic             fault,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [W-1:0] ONE       = W'(1);
  localparam logic [3:0]   LIMIT     = 4'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t       state;
  logic [3:0]   consec;
  logic [W-1:0] dec;
  logic         is_up;
  logic         is_dn;
  logic         is_hold;

  gray_rx_checker_gray2bin #(.W(W)) u_dec (
    .gray (gray_in),
    .bin  (dec)
  );

  // bin_out doubles as the previous binary reference.
  assign is_up   = (dec == bin_out + ONE);
  assign is_dn   = (dec == bin_out - ONE);
  assign is_hold = (dec == bin_out);

  always_ff @(posedge clk) begin
    if (c) begin
      state     <= IDLE;
      consec    <= '0;
      bin_out   <= '0;
      valid_out <= 1'b0;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
      hold      <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
      fault     <= 1'b0;
      err_cnt   <= '0;
    end else begin
      valid_out <= 1'b0;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
      hold      <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;

      if (resync && !valid_in) begin
        state  <= IDLE;
        consec <= '0;
        fault  <= 1'b0;
      end else if (valid_in) begin
        bin_out   <= dec;
        valid_out <= 1'b1;
        if (resync) begin
          state  <= TRACK;
          consec <= '0;
          fault  <= 1'b0;
        end else begin
          case (state)
            TRACK: begin
              if (is_up) begin
                step_up <= 1'b1;
                wrap    <= (bin_out == '1);
                consec  <= '0;
              end else if (is_dn) begin
                step_dn <= 1'b1;
                wrap    <= (bin_out == '0);
                consec  <= '0;
              end else if (is_hold) begin
                hold    <= 1'b1;
                consec  <= '0;
              end else begin
                err    <= 1'b1;
                consec <= consec + 4'd1;
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
                if (consec + 4'd1 == LIMIT) begin
                  state <= FAULT;
                  fault <= 1'b1;
                end
              end
            end
            FAULT: begin
              fault <= 1'b1;
            end
            default: begin
              state  <= TRACK;
              consec <= '0;
              fault  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_rx_checker.sv
// Table-driven self-checking bench for gray_rx_checker with a one-deep expected-output scoreboard.
module tb_gray_rx_checker;

  localparam int W     = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             c = 1'b1;
  logic [W-1:0]     gray_in = '0;
  logic             valid_in = 1'b0;
  logic             resync = 1'b0;
  logic [W-1:0]     bin_out;
  logic             valid_out, step_up, step_dn, hold, wrap, err, fault;
  logic [CNT_W-1:0] err_cnt;

  gray_rx_checker #(.W(W), .ERR_LIMIT(3), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .c         (c),
    .gray_in   (gray_in),
    .valid_in  (valid_in),
    .resync    (resync),
    .bin_out   (bin_out),
    .valid_out (valid_out),
    .step_up   (step_up),
    .step_dn   (step_dn),
    .hold      (hold),
    .wrap      (wrap),
    .err       (err),
    .fault     (fault),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // flags order: valid_out, step_up, step_dn, hold, wrap, err, fault
  typedef struct packed {
    logic [3:0] bin;
    logic [6:0] flags;
    logic [7:0] cnt;
  } out_t;

  typedef struct {
    logic       c;
    logic       v;
    logic       r;
    logic [3:0] g;
    out_t       exp;
  } vec_t;

  out_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic c_, logic v_, logic r_, logic [3:0] g_,
                              logic [3:0] b_, logic [6:0] fl_, logic [7:0] cnt_);
    vec_t v;
    v.c = c_; v.v = v_; v.r = r_; v.g = g_;
    v.exp.bin = b_; v.exp.flags = fl_; v.exp.cnt = cnt_;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string nm);
    out_t got;
    out_t exp;
    @(negedge clk);
    c = v.c; valid_in = v.v; resync = v.r; gray_in = v.g;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    got.bin   = bin_out;
    got.flags = {valid_out, step_up, step_dn, hold, wrap, err, fault};
    got.cnt   = err_cnt;
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got bin=%0d flags(vo,up,dn,hold,wrap,err,fault)=%b cnt=%0d, expected bin=%0d flags=%b cnt=%0d",
               nm, got.bin, got.flags, got.cnt, exp.bin, exp.flags, exp.cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;
    // c, v, r, gray, bin, flags, err_cnt
    tbl.push_back(mk(1, 1, 0, 4'b1111,  0, 7'b0000000, 0)); // reset beats valid
    tbl.push_back(mk(0, 1, 0, 4'b0000,  0, 7'b1000000, 0)); // first sample
    tbl.push_back(mk(0, 1, 0, 4'b0001,  1, 7'b1100000, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0011,  2, 7'b1100000, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0010,  3, 7'b1100000, 0));
    tbl.push_back(mk(0, 0, 0, 4'b1111,  3, 7'b0000000, 0)); // no valid: hold output
    tbl.push_back(mk(0, 1, 1, 4'b1000, 15, 7'b1000000, 0)); // resync+valid: new reference
    tbl.push_back(mk(0, 1, 0, 4'b0000,  0, 7'b1100100, 0)); // up wrap
    tbl.push_back(mk(0, 1, 0, 4'b1000, 15, 7'b1010100, 0)); // down wrap
    tbl.push_back(mk(0, 1, 0, 4'b1001, 14, 7'b1010000, 0));
    tbl.push_back(mk(0, 1, 1, 4'b0011,  2, 7'b1000000, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0011,  2, 7'b1001000, 0)); // hold
    tbl.push_back(mk(0, 1, 0, 4'b0110,  4, 7'b1000010, 1)); // illegal 2->4
    tbl.push_back(mk(0, 1, 0, 4'b0011,  2, 7'b1000010, 2));
    tbl.push_back(mk(0, 1, 0, 4'b0110,  4, 7'b1000011, 3)); // third in a row: fault
    tbl.push_back(mk(0, 1, 0, 4'b1111, 10, 7'b1000001, 3)); // fault: decode only
    tbl.push_back(mk(0, 1, 0, 4'b1000, 15, 7'b1000001, 3));
    tbl.push_back(mk(0, 1, 1, 4'b0101,  6, 7'b1000000, 3)); // resync exits fault
    tbl.push_back(mk(0, 1, 0, 4'b0100,  7, 7'b1100000, 3));
    tbl.push_back(mk(0, 0, 1, 4'b0000,  7, 7'b0000000, 3)); // resync alone -> IDLE
    tbl.push_back(mk(0, 1, 0, 4'b1100,  8, 7'b1000000, 3)); // 7->8 but first sample
    tbl.push_back(mk(1, 0, 0, 4'b0000,  0, 7'b0000000, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000,  0, 7'b1000000, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0110,  4, 7'b1000010, 1));
    tbl.push_back(mk(0, 1, 0, 4'b0000,  0, 7'b1000010, 2));
    tbl.push_back(mk(0, 1, 0, 4'b0001,  1, 7'b1100000, 2)); // legal step breaks the run
    tbl.push_back(mk(0, 1, 0, 4'b0111,  5, 7'b1000010, 3));
    tbl.push_back(mk(0, 1, 0, 4'b0001,  1, 7'b1000010, 4));
    tbl.push_back(mk(0, 1, 0, 4'b0111,  5, 7'b1000011, 5)); // fault with err_cnt=5
    tbl.push_back(mk(1, 1, 1, 4'b0101,  0, 7'b0000000, 0)); // reset in fault
    tbl.push_back(mk(0, 1, 0, 4'b0001,  1, 7'b1000000, 0)); // no pulse after reset
    tbl.push_back(mk(0, 1, 0, 4'b0011,  2, 7'b1100000, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0001,  1, 7'b1010000, 0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Saturation: bursts of three illegal jumps, each re-armed by resync with a sample.
    exp_cnt = 0;
    for (int k = 0; k < 86; k++) begin
      apply(mk(0, 1, 1, 4'b0000, 0, 7'b1000000, 8'(exp_cnt)), $sformatf("sat%0d_first", k));
      for (int j = 0; j < 3; j++) begin
        logic [3:0] g;
        logic [3:0] b;
        g = (j == 1) ? 4'b0000 : 4'b0110;
        b = (j == 1) ? 4'd0 : 4'd4;
        if (exp_cnt < 255) exp_cnt++;
        apply(mk(0, 1, 0, g, b, {1'b1, 4'b0000, 1'b1, (j == 2)}, 8'(exp_cnt)),
              $sformatf("sat%0d_err%0d", k, j));
      end
    end
    apply(mk(0, 1, 0, 4'b0011, 2, 7'b1000001, 8'd255), "sat_fault_hold");
    apply(mk(0, 1, 1, 4'b0011, 2, 7'b1000000, 8'd255), "sat_resync");
    apply(mk(0, 1, 0, 4'b0110, 4, 7'b1000010, 8'd255), "sat_no_wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
